// File: rtl/sound_pkg.sv
// Shared types and default effect table for the sound-effect sequencer.
// A note is a tone period (10 ns units) plus a duration in ticks. Duration 0 ends the effect.
package sound_pkg;

    localparam int SND_NREQ         = 3;
    localparam int SND_MAX_NOTES    = 8;
    localparam int DEFAULT_TICK_DIV = 100000;

    typedef struct packed {
        logic [31:0] period;
        logic [7:0]  dur;
    } note_t;

    typedef note_t [SND_NREQ-1:0][SND_MAX_NOTES-1:0] rom_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } seq_state_t;

    function automatic note_t mk_note(input int unsigned per, input int unsigned dur);
        note_t n;
        n.period = per;
        n.dur    = dur[7:0];
        return n;
    endfunction

    // Effect 0 = fire, 1 = thrust, 2 = explosion. Unlisted slots are zero and end the effect.
    function automatic rom_t default_rom();
        rom_t r;
        r = '0;
        r[0][0] = mk_note(40000, 20);
        r[0][1] = mk_note(60000, 20);
        r[0][2] = mk_note(90000, 30);
        r[1][0] = mk_note(400000, 50);
        r[1][1] = mk_note(0, 10);
        r[1][2] = mk_note(400000, 50);
        r[2][0] = mk_note(800000, 80);
        r[2][1] = mk_note(1200000, 120);
        r[2][2] = mk_note(1600000, 200);
        return r;
    endfunction

    localparam rom_t EFFECT_ROM = default_rom();

endpackage

// File: rtl/sound_tick_gen.sv
// Duration tick generator: one-cycle pulse every TICK_DIV cycles, restartable by a synchronous clear.
module sound_tick_gen
    import sound_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clock100,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

    logic [31:0] cnt;

    assign tick = (cnt == LAST) && !clear;

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/sound_effect_sequencer.sv
// Priority arbiter and note sequencer driving the square-wave tone generator.
// Requests latch into pending; the highest pending index launches or preempts an equal/lower effect.
module sound_effect_sequencer
    import sound_pkg::*;
#(
    parameter int NREQ      = SND_NREQ,
    parameter int MAX_NOTES = SND_MAX_NOTES,
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter note_t [NREQ-1:0][MAX_NOTES-1:0] ROM = EFFECT_ROM,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int NSW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1,
    localparam int NIW = $clog2(MAX_NOTES + 1)
) (
    input  logic            clock100,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            mute,
    output logic [31:0]     period,
    output logic            aud_en,
    output logic            busy,
    output logic [IDW-1:0]  active_id,
    output seq_state_t      dbg_state
);

    seq_state_t      state, state_nx;
    logic [NREQ-1:0] pending, pending_nx, clr_mask;
    logic [IDW-1:0]  sel, active_id_nx;
    logic [NIW-1:0]  note_idx, note_idx_nx;
    logic [7:0]      dur_cnt, dur_cnt_nx;
    logic [31:0]     period_nx;
    logic            sounding, sounding_nx;
    logic            tick, tick_clr, launch, any_pending, can_preempt;
    note_t           note;

    sound_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock100 (clock100),
        .reset_n  (reset_n),
        .clear    (tick_clr),
        .tick     (tick)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pending[i]) sel = IDW'(i);
        end
    end

    assign any_pending = |pending;
    assign can_preempt = any_pending && (sel >= active_id);
    // Index MAX_NOTES is past the table and reads as an end marker.
    assign note = (note_idx < NIW'(MAX_NOTES)) ? ROM[active_id][note_idx[NSW-1:0]] : '0;
    assign dbg_state = state;

    always_comb begin
        state_nx     = state;
        active_id_nx = active_id;
        note_idx_nx  = note_idx;
        dur_cnt_nx   = dur_cnt;
        period_nx    = period;
        sounding_nx  = sounding;
        tick_clr     = 1'b0;
        launch       = 1'b0;
        clr_mask     = '0;
        case (state)
            IDLE: launch = any_pending;
            LOAD: begin
                if (can_preempt) begin
                    launch = 1'b1;
                end else if (note.dur == 8'd0) begin
                    sounding_nx = 1'b0;
                    state_nx    = IDLE;
                end else begin
                    period_nx   = note.period;
                    sounding_nx = (note.period != '0);
                    dur_cnt_nx  = note.dur;
                    tick_clr    = 1'b1;
                    state_nx    = PLAY;
                end
            end
            PLAY: begin
                if (can_preempt) begin
                    launch = 1'b1;
                end else if (tick) begin
                    dur_cnt_nx = dur_cnt - 8'd1;
                    if (dur_cnt == 8'd1) begin
                        note_idx_nx = note_idx + NIW'(1);
                        state_nx    = LOAD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (launch) begin
            active_id_nx  = sel;
            clr_mask[sel] = 1'b1;
            note_idx_nx   = '0;
            state_nx      = LOAD;
        end
        // A request arriving while its own slot is being launched stays latched.
        pending_nx = (pending & ~clr_mask) | req;
    end

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending   <= '0;
            active_id <= '0;
            note_idx  <= '0;
            dur_cnt   <= '0;
            period    <= '0;
            sounding  <= 1'b0;
            aud_en    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            active_id <= active_id_nx;
            note_idx  <= note_idx_nx;
            dur_cnt   <= dur_cnt_nx;
            period    <= period_nx;
            sounding  <= sounding_nx;
            aud_en    <= sounding_nx && !mute;
            busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sound_effect_sequencer.sv
// Bench for sound_effect_sequencer: scripted scenarios plus random requests against a
// schedule model that expands each launched effect into its per-cycle output timeline.
module tb_sound_effect_sequencer;
    import sound_pkg::*;

    localparam int T    = 4;
    localparam int MAXC = 6000;

    function automatic rom_t build_test_rom();
        rom_t r;
        r = '0;
        r[0][0] = mk_note(100000, 2);
        r[0][1] = mk_note(0, 3);
        r[0][2] = mk_note(50000, 1);
        r[0][3] = mk_note(7777, 0);
        for (int k = 0; k < 8; k++) r[1][k] = mk_note(1000 * (k + 1), (k % 2) + 1);
        r[2][0] = mk_note(30000, 3);
        r[2][1] = mk_note(40000, 1);
        return r;
    endfunction

    localparam rom_t TROM = build_test_rom();

    logic        clock100 = 1'b0;
    logic        reset_n  = 1'b0;
    logic [2:0]  req      = '0;
    logic        mute     = 1'b0;
    logic [31:0] period;
    logic        aud_en, busy;
    logic [1:0]  active_id;
    seq_state_t  dbg_state;

    sound_effect_sequencer #(
        .NREQ(3), .MAX_NOTES(8), .TICK_DIV(T), .ROM(TROM)
    ) dut (
        .clock100  (clock100),
        .reset_n   (reset_n),
        .req       (req),
        .mute      (mute),
        .period    (period),
        .aud_en    (aud_en),
        .busy      (busy),
        .active_id (active_id),
        .dbg_state (dbg_state)
    );

    always #5 clock100 = ~clock100;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit [31:0] e_period [MAXC];
    bit        e_snd    [MAXC];
    bit        e_busy   [MAXC];
    int        e_id     [MAXC];
    bit        mute_h   [MAXC];
    logic [2:0] pend_m;

    function automatic int highest(input logic [2:0] p);
        int h;
        h = 0;
        for (int i = 0; i < 3; i++) if (p[i]) h = i;
        return h;
    endfunction

    // Expected {period, aud_en, busy, active_id} in cycle n.
    function automatic logic [35:0] expv(input int n);
        bit en;
        en = e_snd[n] && !(n > 0 && mute_h[n-1]);
        return {e_period[n], en, e_busy[n], 2'(e_id[n])};
    endfunction

    // Effect sel launched in cycle n: LOAD at n+1, each note audible for dur*T play cycles
    // plus the following LOAD cycle; after the closing LOAD the period holds and sound stops.
    task automatic schedule(input int n, input int sel);
        int c, len;
        bit [31:0] per;
        note_t nt;
        per = e_period[n];
        e_period[n+1] = e_period[n];
        e_snd[n+1]    = e_snd[n];
        e_busy[n+1]   = 1'b1;
        e_id[n+1]     = sel;
        c = n + 1;
        for (int k = 0; k <= 8; k++) begin
            nt = (k < 8) ? TROM[sel][k] : '0;
            if (nt.dur == 8'd0) begin
                for (int j = c + 1; j < MAXC; j++) begin
                    e_period[j] = per; e_snd[j] = 1'b0; e_busy[j] = 1'b0; e_id[j] = sel;
                end
                break;
            end
            len = int'(nt.dur) * T;
            for (int j = c + 1; j <= c + len + 1 && j < MAXC; j++) begin
                e_period[j] = nt.period; e_snd[j] = (nt.period != 0); e_busy[j] = 1'b1; e_id[j] = sel;
            end
            per = nt.period;
            c   = c + len + 1;
        end
    endtask

    task automatic model_reset(input int from);
        pend_m = '0;
        for (int j = from; j < MAXC; j++) begin
            e_period[j] = '0; e_snd[j] = 1'b0; e_busy[j] = 1'b0; e_id[j] = 0;
        end
    endtask

    // Advance the model by the current cycle, apply inputs and move to the next negedge.
    task automatic step(input logic [2:0] r, input logic m);
        int s;
        if (pend_m != 3'b000) begin
            s = highest(pend_m);
            if (!e_busy[cyc] || s >= e_id[cyc]) begin
                schedule(cyc, s);
                pend_m[s] = 1'b0;
            end
        end
        pend_m      = pend_m | r;
        mute_h[cyc] = m;
        req  = r;
        mute = m;
        @(posedge clock100);
        cyc++;
        @(negedge clock100);
    endtask

    task automatic test_reset();
        checks++;
        if (period !== 32'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++;
        if (aud_en !== 1'b0) begin errors++; $display("FAIL reset_aud_en got=%b exp=0", aud_en); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (active_id !== 2'd0) begin errors++; $display("FAIL reset_active_id got=%0d exp=0", active_id); end
        checks++;
        if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_single_effect();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            if (cyc == t0 + 3 || cyc == t0 + 12 || cyc == t0 + 25 || cyc == t0 + 30) begin
                checks++;
                if ((cyc == t0 + 3  && {period, aud_en, busy} !== {32'd100000, 1'b1, 1'b1}) ||
                    (cyc == t0 + 12 && {period, aud_en, busy} !== {32'd0, 1'b0, 1'b1}) ||
                    (cyc == t0 + 25 && {period, aud_en, busy} !== {32'd50000, 1'b1, 1'b1}) ||
                    (cyc == t0 + 30 && {period, aud_en, busy} !== {32'd50000, 1'b0, 1'b0})) begin
                    errors++; $display("FAIL single_milestone offset=%0d got=%0d/%b/%b", cyc - t0, period, aud_en, busy);
                end
            end
            step((i == 0) ? 3'b001 : 3'b000, 1'b0);
        end
    endtask

    task automatic test_preempt();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL preempt cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            if (cyc == t0 + 8) begin
                checks++;
                if (active_id !== 2'd2) begin errors++; $display("FAIL preempt_id got=%0d exp=2", active_id); end
            end
            if (cyc == t0 + 9) begin
                checks++;
                if ({period, aud_en} !== {32'd30000, 1'b1}) begin errors++; $display("FAIL preempt_note got=%0d/%b exp=30000/1", period, aud_en); end
            end
            if (cyc == t0 + 39) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL preempt_no_resume busy got=%b exp=0", busy); end
            end
            step((i == 0) ? 3'b001 : (i == 6) ? 3'b100 : 3'b000, 1'b0);
        end
    endtask

    task automatic test_queued();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 90; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL queued cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            if (cyc == t0 + 21) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL queued_idle_gap busy got=%b exp=0", busy); end
            end
            if (cyc == t0 + 22) begin
                checks++;
                if ({busy, active_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL queued_launch got=%b/%0d exp=1/1", busy, active_id); end
            end
            if (cyc == t0 + 23) begin
                checks++;
                if (period !== 32'd1000) begin errors++; $display("FAIL queued_first_note got=%0d exp=1000", period); end
            end
            step((i == 0) ? 3'b100 : (i == 5) ? 3'b010 : 3'b000, 1'b0);
        end
    endtask

    task automatic test_retrigger();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 95; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL retrigger cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            if (cyc == t0 + 23) begin
                checks++;
                if (period !== 32'd4000) begin errors++; $display("FAIL retrigger_note3 got=%0d exp=4000", period); end
            end
            if (cyc == t0 + 26 || cyc == t0 + 30) begin
                checks++;
                if ({period, aud_en} !== {32'd1000, 1'b1}) begin errors++; $display("FAIL retrigger_restart offset=%0d got=%0d exp=1000", cyc - t0, period); end
            end
            if (cyc == t0 + 31) begin
                checks++;
                if (period !== 32'd2000) begin errors++; $display("FAIL retrigger_next got=%0d exp=2000", period); end
            end
            step((i == 0 || i == 23) ? 3'b010 : 3'b000, 1'b0);
        end
    endtask

    task automatic test_mute();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL mute cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            checks++;
            if (aud_en !== 1'b0) begin errors++; $display("FAIL mute_aud_en cyc=%0d got=%b exp=0", cyc, aud_en); end
            if (cyc == t0 + 25) begin
                checks++;
                if ({period, busy} !== {32'd50000, 1'b1}) begin errors++; $display("FAIL mute_timing got=%0d/%b exp=50000/1", period, busy); end
            end
            step((i == 0) ? 3'b001 : 3'b000, 1'b1);
        end
        step(3'b000, 1'b0);
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL midreset_pre cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            step((i == 0) ? 3'b010 : (i == 9) ? 3'b001 : 3'b000, 1'b0);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({period, aud_en, busy, active_id} !== 36'd0) begin
            errors++; $display("FAIL midreset_async got=%h exp=0", {period, aud_en, busy, active_id});
        end
        model_reset(cyc + 1);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL midreset_post cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            step(3'b000, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [2:0] r;
        logic m;
        m = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            checks++;
            if ({period, aud_en, busy, active_id} !== expv(cyc)) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {period, aud_en, busy, active_id}, expv(cyc));
            end
            r = '0;
            if (i < 1500 && $urandom_range(0, 15) == 0) r = 3'($urandom_range(1, 7));
            if (i < 1500 && $urandom_range(0, 63) == 0) m = ~m;
            if (i >= 1500) m = 1'b0;
            step(r, m);
        end
    endtask

    initial begin
        for (int j = 0; j < MAXC; j++) mute_h[j] = 1'b0;
        model_reset(0);
        repeat (3) @(negedge clock100);
        test_reset();
        reset_n = 1'b1;
        test_single_effect();
        test_preempt();
        test_queued();
        test_retrigger();
        test_mute();
        test_reset_mid_play();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
